uart_hex_cmd: RTL and testbench

ASCII hex command parser that sits directly downstream of the `uart` receive FIFO. It pops received bytes, optionally echoes each byte into the `uart` transmit FIFO, and parses lines of the form two hex digits plus a terminator into an 8-bit command value. Accepted values drive the LEDs and display logic of the board top level. Malformed lines are counted and flagged.

---
 rtl/uart_hex_cmd_pkg.sv | 27 ++
 rtl/uart_hex_cmd_if.sv | 34 +++
 rtl/hex_ascii_decode.sv | 34 +++
 rtl/uart_hex_cmd.sv | 130 +++++++++++++
 tb/tb_uart_hex_cmd.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_hex_cmd_pkg.sv
// Shared definitions for the UART hex command parser.
// Holds the ASCII constants the decoder compares against and the parser FSM
// state encoding. No ports.
package uart_hex_cmd_pkg;

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;
    localparam logic [7:0] CH_UA = 8'h41;  // 'A'
    localparam logic [7:0] CH_UF = 8'h46;  // 'F'
    localparam logic [7:0] CH_LA = 8'h61;  // 'a'
    localparam logic [7:0] CH_LF_HEX = 8'h66;  // 'f'

    localparam logic [1:0] ST_D0_ENC   = 2'd0;
    localparam logic [1:0] ST_D1_ENC   = 2'd1;
    localparam logic [1:0] ST_TERM_ENC = 2'd2;
    localparam logic [1:0] ST_ERR_ENC  = 2'd3;

    typedef enum logic [1:0] {
        StD0   = ST_D0_ENC,    // expecting high digit (or blank line)
        StD1   = ST_D1_ENC,    // expecting low digit
        StTerm = ST_TERM_ENC,  // expecting terminator
        StErr  = ST_ERR_ENC    // bad line, skipping to terminator
    } state_e;

endpackage

// File: rtl/uart_hex_cmd_if.sv
// FIFO-side handshake bundle for the hex command parser.
//   rx_empty, r_data : rx FIFO empty flag and first-word-fall-through head byte
//   rd_uart          : rx FIFO pop strobe
//   tx_full          : tx FIFO full flag
//   wr_uart, w_data  : tx FIFO push strobe and byte
// master = parser side, slave = FIFO side.
interface uart_hex_cmd_if;

    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] w_data;

    modport master (
        input  rx_empty,
        input  r_data,
        input  tx_full,
        output rd_uart,
        output wr_uart,
        output w_data
    );

    modport slave (
        output rx_empty,
        output r_data,
        output tx_full,
        input  rd_uart,
        input  wr_uart,
        input  w_data
    );

endinterface

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII character classifier.
//   ch      : input byte
//   is_hex  : ch is 0-9, A-F or a-f
//   is_term : ch is CR or LF
//   nibble  : hex value of ch (0 when not hex)
module hex_ascii_decode
    import uart_hex_cmd_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_hex,
    output logic       is_term,
    output logic [3:0] nibble
);

    logic is_digit;
    logic is_upper;
    logic is_lower;

    always_comb begin
        is_digit = (ch >= CH_0) && (ch <= CH_9);
        is_upper = (ch >= CH_UA) && (ch <= CH_UF);
        is_lower = (ch >= CH_LA) && (ch <= CH_LF_HEX);
        is_hex   = is_digit || is_upper || is_lower;
        is_term  = (ch == CH_CR) || (ch == CH_LF);
        nibble   = 4'd0;
        if (is_digit) begin
            nibble = ch[3:0];
        end else if (is_upper || is_lower) begin
            // Both letter ranges start at xx1 in the low nibble: 'A'/'a' -> 1 + 9 = 10.
            nibble = ch[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/uart_hex_cmd.sv
// ASCII hex command parser downstream of the uart rx FIFO.
// Pops one byte per cycle, optionally echoes it to the tx FIFO, and parses
// lines of exactly two hex digits plus CR/LF into an 8-bit command.
//   clk, reset : clock, synchronous active-high reset
//   bus        : rx/tx FIFO handshake (master side)
//   cmd_data   : last accepted command value
//   cmd_valid  : one-cycle pulse when cmd_data updates
//   err_tick   : one-cycle pulse per rejected line
//   err_cnt    : saturating count of rejected lines
module uart_hex_cmd
    import uart_hex_cmd_pkg::*;
#(
    parameter bit          ECHO  = 1'b1,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    uart_hex_cmd_if.master   bus,
    output logic [7:0]       cmd_data,
    output logic             cmd_valid,
    output logic             err_tick,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [ERR_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [3:0]       hi_q, hi_d;
    logic [3:0]       lo_q, lo_d;
    logic [7:0]       cmd_data_q;
    logic             cmd_valid_q;
    logic             err_tick_q;
    logic [ERR_W-1:0] err_cnt_q;

    logic             pop;
    logic             accept;
    logic             error;
    logic             is_hex;
    logic             is_term;
    logic [3:0]       nibble;

    hex_ascii_decode u_decode (
        .ch      (bus.r_data),
        .is_hex  (is_hex),
        .is_term (is_term),
        .nibble  (nibble)
    );

    // Pop and echo share one strobe so an echoed design never drops a byte.
    assign pop         = !reset && !bus.rx_empty && (!ECHO || !bus.tx_full);
    assign bus.rd_uart = pop;
    assign bus.wr_uart = pop && ECHO;
    assign bus.w_data  = bus.r_data;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        accept  = 1'b0;
        error   = 1'b0;
        if (pop) begin
            case (state_q)
                StD0: begin
                    if (is_hex) begin
                        hi_d    = nibble;
                        state_d = StD1;
                    end else if (!is_term) begin
                        state_d = StErr;
                    end
                end
                StD1: begin
                    if (is_hex) begin
                        lo_d    = nibble;
                        state_d = StTerm;
                    end else if (is_term) begin
                        error   = 1'b1;
                        state_d = StD0;
                    end else begin
                        state_d = StErr;
                    end
                end
                StTerm: begin
                    if (is_term) begin
                        accept  = 1'b1;
                        state_d = StD0;
                    end else begin
                        state_d = StErr;
                    end
                end
                StErr: begin
                    if (is_term) begin
                        error   = 1'b1;
                        state_d = StD0;
                    end
                end
                default: state_d = StD0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StD0;
            hi_q        <= 4'd0;
            lo_q        <= 4'd0;
            cmd_data_q  <= 8'h00;
            cmd_valid_q <= 1'b0;
            err_tick_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            cmd_valid_q <= accept;
            err_tick_q  <= error;
            if (accept) begin
                cmd_data_q <= {hi_q, lo_q};
            end
            if (error && (err_cnt_q != CNT_MAX)) begin
                err_cnt_q <= err_cnt_q + ERR_W'(1);
            end
        end
    end

    assign cmd_data  = cmd_data_q;
    assign cmd_valid = cmd_valid_q;
    assign err_tick  = err_tick_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_hex_cmd.sv
// Self-checking bench for uart_hex_cmd: one ECHO=1 and one ECHO=0 instance fed
// the same byte stream from separate FIFO models, checked against a line-level
// reference model.
module tb_uart_hex_cmd;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tf  = 1'b0;

    always #5 clk = ~clk;

    uart_hex_cmd_if bus0 ();
    uart_hex_cmd_if bus1 ();

    logic [7:0] cmd_data0, cmd_data1;
    logic       cmd_valid0, cmd_valid1;
    logic       err_tick0, err_tick1;
    logic [7:0] err_cnt0, err_cnt1;

    uart_hex_cmd #(.ECHO(1'b1), .ERR_W(8)) dut0 (
        .clk       (clk),
        .reset     (rst),
        .bus       (bus0),
        .cmd_data  (cmd_data0),
        .cmd_valid (cmd_valid0),
        .err_tick  (err_tick0),
        .err_cnt   (err_cnt0)
    );

    uart_hex_cmd #(.ECHO(1'b0), .ERR_W(8)) dut1 (
        .clk       (clk),
        .reset     (rst),
        .bus       (bus1),
        .cmd_data  (cmd_data1),
        .cmd_valid (cmd_valid1),
        .err_tick  (err_tick1),
        .err_cnt   (err_cnt1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    // Line-level reference model state per instance.
    int         llen[2]      = '{0, 0};
    logic [7:0] lc0[2]       = '{8'h00, 8'h00};
    logic [7:0] lc1[2]       = '{8'h00, 8'h00};
    int         exp_data[2]  = '{0, 0};
    bit         exp_valid[2] = '{1'b0, 1'b0};
    bit         exp_tick[2]  = '{1'b0, 1'b0};
    int         exp_cnt[2]   = '{0, 0};

    int n_pop0, n_pop1, n_wr0, n_wr1, n_valid0, n_tick0;
    logic [7:0] got0[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int hexval(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    function automatic void model_reset(input int k);
        llen[k]      = 0;
        exp_data[k]  = 0;
        exp_valid[k] = 1'b0;
        exp_tick[k]  = 1'b0;
        exp_cnt[k]   = 0;
    endfunction

    // A non-empty line is accepted only if it is exactly two hex characters.
    function automatic void model_byte(input int k, input logic [7:0] b);
        exp_valid[k] = 1'b0;
        exp_tick[k]  = 1'b0;
        if (b == 8'h0D || b == 8'h0A) begin
            if (llen[k] == 0) begin
                // blank line: ignored
            end else if (llen[k] == 2 && hexval(lc0[k]) >= 0 && hexval(lc1[k]) >= 0) begin
                exp_valid[k] = 1'b1;
                exp_data[k]  = hexval(lc0[k]) * 16 + hexval(lc1[k]);
            end else begin
                exp_tick[k] = 1'b1;
                if (exp_cnt[k] < 255) exp_cnt[k]++;
            end
            llen[k] = 0;
        end else begin
            if (llen[k] == 0) lc0[k] = b;
            else if (llen[k] == 1) lc1[k] = b;
            if (llen[k] < 1000) llen[k]++;
        end
    endfunction

    task automatic apply();
        bus0.rx_empty = (q0.size() == 0);
        bus0.r_data   = (q0.size() != 0) ? q0[0] : 8'h00;
        bus1.rx_empty = (q1.size() == 0);
        bus1.r_data   = (q1.size() != 0) ? q1[0] : 8'h00;
        bus0.tx_full  = tf;
        bus1.tx_full  = tf;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            q0.push_back(s[i]);
            q1.push_back(s[i]);
        end
        apply();
    endtask

    task automatic clear_counts();
        n_pop0 = 0; n_pop1 = 0; n_wr0 = 0; n_wr1 = 0; n_valid0 = 0; n_tick0 = 0;
        got0.delete();
    endtask

    task automatic tick();
        bit ep0, ep1;
        logic [7:0] b;
        apply();
        #1;
        ep0 = !rst && (q0.size() != 0) && !tf;
        ep1 = !rst && (q1.size() != 0);
        chk("rd0", bus0.rd_uart, ep0);
        chk("wr0", bus0.wr_uart, ep0);
        chk("rd1", bus1.rd_uart, ep1);
        chk("wr1", bus1.wr_uart, 0);
        if (ep0) chk("w_data0", bus0.w_data, q0[0]);
        if (bus0.rd_uart === 1'b1) n_pop0++;
        if (bus0.wr_uart === 1'b1) n_wr0++;
        if (bus1.rd_uart === 1'b1) n_pop1++;
        if (bus1.wr_uart === 1'b1) n_wr1++;
        @(posedge clk);
        if (rst) begin
            model_reset(0);
            model_reset(1);
        end else begin
            if (ep0) begin
                b = q0.pop_front();
                model_byte(0, b);
            end else begin
                exp_valid[0] = 1'b0;
                exp_tick[0]  = 1'b0;
            end
            if (ep1) begin
                b = q1.pop_front();
                model_byte(1, b);
            end else begin
                exp_valid[1] = 1'b0;
                exp_tick[1]  = 1'b0;
            end
        end
        #1;
        chk("cmd_valid0", cmd_valid0, exp_valid[0]);
        chk("err_tick0", err_tick0, exp_tick[0]);
        chk("cmd_data0", cmd_data0, exp_data[0]);
        chk("err_cnt0", err_cnt0, exp_cnt[0]);
        chk("cmd_valid1", cmd_valid1, exp_valid[1]);
        chk("err_tick1", err_tick1, exp_tick[1]);
        chk("cmd_data1", cmd_data1, exp_data[1]);
        chk("err_cnt1", err_cnt1, exp_cnt[1]);
        chk("excl0", cmd_valid0 & err_tick0, 0);
        if (cmd_valid0 === 1'b1) begin
            n_valid0++;
            got0.push_back(cmd_data0);
        end
        if (err_tick0 === 1'b1) n_tick0++;
        apply();
    endtask

    task automatic drain();
        int guard = 0;
        while ((q0.size() != 0 || q1.size() != 0) && guard < 3000) begin
            tick();
            guard++;
        end
        chk("drain_done", q0.size() + q1.size(), 0);
        tick();
        tick();
    endtask

    initial begin
        apply();
        // Reset: outputs at reset values, no pops even with data pending.
        rst = 1'b1;
        push_str("5");
        tick();
        tick();
        chk("rst_cmd_data", cmd_data0, 8'h00);
        chk("rst_err_cnt", err_cnt0, 8'h00);
        q0.delete();
        q1.delete();
        rst = 1'b0;
        apply();
        tick();

        // "3F\r": three pops with echo, single accept.
        clear_counts();
        push_str("3F\r");
        drain();
        chk("t1_pops", n_pop0, 3);
        chk("t1_echo", n_wr0, 3);
        chk("t1_valid", n_valid0, 1);
        chk("t1_data", cmd_data0, 8'h3F);
        chk("t1_err", err_cnt0, 0);

        // Back-to-back lines with a trailing LF to ignore.
        clear_counts();
        push_str("a5\r\n00\n");
        for (int i = 0; i < 7; i++) tick();
        chk("t2_pops", n_pop0, 7);
        chk("t2_q_empty", q0.size(), 0);
        tick();
        tick();
        chk("t2_nvalid", n_valid0, 2);
        if (got0.size() == 2) begin
            chk("t2_first", got0[0], 8'hA5);
            chk("t2_second", got0[1], 8'h00);
        end

        // Short, bad-digit and long lines.
        clear_counts();
        push_str("4\r1G\r123\r");
        drain();
        chk("t3_ticks", n_tick0, 3);
        chk("t3_cnt", err_cnt0, 3);
        chk("t3_data", cmd_data0, 8'h00);
        chk("t3_valid", n_valid0, 0);

        // tx_full stall: ECHO=1 holds, ECHO=0 proceeds.
        clear_counts();
        tf = 1'b1;
        push_str("7E\r");
        for (int i = 0; i < 20; i++) tick();
        chk("t4_stall_pops", n_pop0, 0);
        chk("t4_stall_wr", n_wr0, 0);
        chk("t4_noecho_pops", n_pop1, 3);
        chk("t4_noecho_wr", n_wr1, 0);
        chk("t4_noecho_data", cmd_data1, 8'h7E);
        tf = 1'b0;
        drain();
        chk("t4_data", cmd_data0, 8'h7E);

        // Saturation of err_cnt.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_counts();
        for (int i = 0; i < 260; i++) push_str("X\r");
        drain();
        chk("t5_cnt", err_cnt0, 8'hFF);
        chk("t5_ticks", n_tick0, 260);

        // Reset mid-line discards the partial line.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push_str("C");
        drain();
        clear_counts();
        rst = 1'b1;
        push_str("3\r");
        tick();
        rst = 1'b0;
        drain();
        chk("t6_cnt", err_cnt0, 1);
        chk("t6_ticks", n_tick0, 1);
        chk("t6_valid", n_valid0, 0);

        // Randomized mix of characters, gaps, tx_full and occasional reset.
        begin
            string hexs = "0123456789abcdefABCDEF";
            logic [7:0] c;
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 3) != 0) begin
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3, 4: c = hexs[$urandom_range(0, 21)];
                        5: c = 8'h0D;
                        6: c = 8'h0A;
                        default: c = 8'($urandom_range(0, 255));
                    endcase
                    q0.push_back(c);
                    q1.push_back(c);
                end
                tf  = ($urandom_range(0, 3) == 0);
                rst = ($urandom_range(0, 99) == 0);
                tick();
            end
            rst = 1'b0;
            tf  = 1'b0;
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
